// File: rtl/leve_idec_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for leve_idec.
// master = surrounding pipeline (fetch buffer + execute), slave = the decode stage.
interface leve_idec_if #(
  parameter int XLEN = 64
);
  logic            INST_VALID;
  logic            INST_READY;
  logic [31:0]     INST_DATA;
  logic            FLUSH;
  logic [XLEN-1:0] REDIR_PC;
  logic            DEC_VALID;
  logic            DEC_READY;
  logic [XLEN-1:0] DEC_PC;
  logic [31:0]     DEC_INST;
  logic [3:0]      DEC_CLASS;
  logic [4:0]      DEC_RD;
  logic [4:0]      DEC_RS1;
  logic [4:0]      DEC_RS2;
  logic [2:0]      DEC_FUNCT3;
  logic            DEC_ALT;
  logic [XLEN-1:0] DEC_IMM;

  modport master (
    output INST_VALID, INST_DATA, FLUSH, REDIR_PC, DEC_READY,
    input  INST_READY, DEC_VALID, DEC_PC, DEC_INST, DEC_CLASS,
           DEC_RD, DEC_RS1, DEC_RS2, DEC_FUNCT3, DEC_ALT, DEC_IMM
  );

  modport slave (
    input  INST_VALID, INST_DATA, FLUSH, REDIR_PC, DEC_READY,
    output INST_READY, DEC_VALID, DEC_PC, DEC_INST, DEC_CLASS,
           DEC_RD, DEC_RS1, DEC_RS2, DEC_FUNCT3, DEC_ALT, DEC_IMM
  );
endinterface

// File: rtl/leve_idec.sv
// RV64I decode stage: PC-tags and decodes one instruction per cycle, 1-cycle latency.
// Output register + skid register; INST_READY is registered (!skid full), FLUSH wins over everything.
module leve_idec #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic        CLK,
  input logic        RSTn,
  leve_idec_if.slave bus
);
  localparam logic [3:0] C_ILL = 4'd0,  C_LUI = 4'd1,  C_AUIPC = 4'd2,   C_JAL = 4'd3;
  localparam logic [3:0] C_JALR = 4'd4, C_BR = 4'd5,   C_LOAD = 4'd6,    C_STORE = 4'd7;
  localparam logic [3:0] C_OPI = 4'd8,  C_OP = 4'd9,   C_OPI32 = 4'd10,  C_OP32 = 4'd11;
  localparam logic [3:0] C_MISC = 4'd12, C_SYS = 4'd13;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [3:0]      cls;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            alt;
    logic [XLEN-1:0] imm;
  } dec_t;

  dec_t            out_q, skid_q, nxt;
  logic            out_vld, skid_vld, rdy_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     w;
  logic [2:0]      f3;
  logic [3:0]      cls;
  logic            use_rd, use_rs1, use_rs2;
  imm_fmt_t        fmt;
  logic [XLEN-1:0] imm;
  logic            acc, out_free;

  assign w  = bus.INST_DATA;
  assign f3 = w[14:12];

  always_comb begin
    cls     = C_ILL;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    fmt     = IMM_NONE;
    case (w[6:0])
      7'b0110111: begin cls = C_LUI;   use_rd = 1'b1; fmt = IMM_U; end
      7'b0010111: begin cls = C_AUIPC; use_rd = 1'b1; fmt = IMM_U; end
      7'b1101111: begin cls = C_JAL;   use_rd = 1'b1; fmt = IMM_J; end
      7'b1100111: if (f3 == 3'b000) begin
        cls = C_JALR; use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I;
      end
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
        cls = C_BR; use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_B;
      end
      7'b0000011: if (f3 != 3'b111) begin
        cls = C_LOAD; use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I;
      end
      7'b0100011: if (f3 <= 3'b011) begin
        cls = C_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_S;
      end
      7'b0010011: begin cls = C_OPI;   use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; end
      7'b0110011: begin cls = C_OP;    use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0011011: begin cls = C_OPI32; use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; end
      7'b0111011: begin cls = C_OP32;  use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0001111: begin cls = C_MISC;  use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; end
      7'b1110011: begin cls = C_SYS;   use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; end
      default: ;
    endcase

    case (fmt)
      IMM_I:   imm = {{(XLEN-12){w[31]}}, w[31:20]};
      IMM_S:   imm = {{(XLEN-12){w[31]}}, w[31:25], w[11:7]};
      IMM_B:   imm = {{(XLEN-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){w[31]}}, w[31:12], 12'b0};
      IMM_J:   imm = {{(XLEN-21){w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm = '0;
    endcase

    nxt        = '0;
    nxt.pc     = pc_q;
    nxt.inst   = w;
    nxt.cls    = cls;
    nxt.rd     = use_rd  ? w[11:7]  : 5'd0;
    nxt.rs1    = use_rs1 ? w[19:15] : 5'd0;
    nxt.rs2    = use_rs2 ? w[24:20] : 5'd0;
    nxt.funct3 = f3;
    nxt.alt    = w[30];
    nxt.imm    = imm;
  end

  assign acc      = bus.INST_VALID && rdy_q && !bus.FLUSH;
  assign out_free = !out_vld || bus.DEC_READY;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
      pc_q     <= RESET_PC;
    end else if (bus.FLUSH) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
      pc_q     <= bus.REDIR_PC & ~XLEN'(3);
    end else begin
      if (acc) pc_q <= pc_q + XLEN'(4);
      // skid always refills the output first so order is preserved
      if (out_free) begin
        if (skid_vld) begin
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= 1'b0;
        end else if (acc) begin
          out_q   <= nxt;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
        rdy_q <= 1'b1;
      end else begin
        if (acc) begin
          skid_q   <= nxt;
          skid_vld <= 1'b1;
        end
        rdy_q <= !(skid_vld || acc);
      end
    end
  end

  assign bus.INST_READY = rdy_q;
  assign bus.DEC_VALID  = out_vld;
  assign bus.DEC_PC     = out_q.pc;
  assign bus.DEC_INST   = out_q.inst;
  assign bus.DEC_CLASS  = out_q.cls;
  assign bus.DEC_RD     = out_q.rd;
  assign bus.DEC_RS1    = out_q.rs1;
  assign bus.DEC_RS2    = out_q.rs2;
  assign bus.DEC_FUNCT3 = out_q.funct3;
  assign bus.DEC_ALT    = out_q.alt;
  assign bus.DEC_IMM    = out_q.imm;
endmodule

// File: tb/tb_leve_idec.sv
// Bench for leve_idec: directed scenarios plus random traffic checked against a 2-deep queue model.
module tb_leve_idec;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  leve_idec_if #(.XLEN(64)) bus ();

  leve_idec #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint unsigned pc;
    longint unsigned inst;
    int              cls;
    int              rd;
    int              rs1;
    int              rs2;
    int              f3;
    int              alt;
    longint unsigned imm;
  } ref_t;

  ref_t            q[$];
  longint unsigned m_pc = RST_PC;
  bit              rdy_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned sext(input longint unsigned v, input int n);
    if (((v >> (n - 1)) & 1) != 0) return v - (64'd1 << n);
    return v;
  endfunction

  // Decode from the instruction-set tables: class by opcode, then field usage by class.
  function automatic ref_t ref_decode(input logic [31:0] word, input longint unsigned pc);
    ref_t            r;
    longint unsigned u;
    int              op;
    u = 64'(word);
    op = int'(u & 127);
    r.pc = pc;
    r.inst = u;
    r.f3 = int'((u >> 12) & 7);
    r.alt = int'((u >> 30) & 1);
    case (op)
      'h37: r.cls = 1;
      'h17: r.cls = 2;
      'h6F: r.cls = 3;
      'h67: r.cls = (r.f3 == 0) ? 4 : 0;
      'h63: r.cls = (r.f3 == 2 || r.f3 == 3) ? 0 : 5;
      'h03: r.cls = (r.f3 == 7) ? 0 : 6;
      'h23: r.cls = (r.f3 > 3) ? 0 : 7;
      'h13: r.cls = 8;
      'h33: r.cls = 9;
      'h1B: r.cls = 10;
      'h3B: r.cls = 11;
      'h0F: r.cls = 12;
      'h73: r.cls = 13;
      default: r.cls = 0;
    endcase
    r.rd  = (((32'h3F5E >> r.cls) & 1) != 0) ? int'((u >> 7) & 31)  : 0;
    r.rs1 = (((32'h3FF0 >> r.cls) & 1) != 0) ? int'((u >> 15) & 31) : 0;
    r.rs2 = (((32'h0AA0 >> r.cls) & 1) != 0) ? int'((u >> 20) & 31) : 0;
    case (r.cls)
      4, 6, 8, 10, 12, 13: r.imm = sext(u >> 20, 12);
      7:    r.imm = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
      5:    r.imm = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                         (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      1, 2: r.imm = sext(u & 64'hFFFF_F000, 32);
      3:    r.imm = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                         (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      default: r.imm = 0;
    endcase
    return r;
  endfunction

  task automatic check_state();
    ref_t r;
    chk("dec_valid", 64'(bus.DEC_VALID), 64'(q.size() > 0));
    chk("inst_ready", 64'(bus.INST_READY), 64'(rdy_en && q.size() < 2));
    if (q.size() > 0) begin
      r = q[0];
      chk("dec_pc", bus.DEC_PC, r.pc);
      chk("dec_inst", 64'(bus.DEC_INST), r.inst);
      chk("dec_class", 64'(bus.DEC_CLASS), 64'(r.cls));
      chk("dec_rd", 64'(bus.DEC_RD), 64'(r.rd));
      chk("dec_rs1", 64'(bus.DEC_RS1), 64'(r.rs1));
      chk("dec_rs2", 64'(bus.DEC_RS2), 64'(r.rs2));
      chk("dec_funct3", 64'(bus.DEC_FUNCT3), 64'(r.f3));
      chk("dec_alt", 64'(bus.DEC_ALT), 64'(r.alt));
      chk("dec_imm", bus.DEC_IMM, r.imm);
    end
  endtask

  // One clock: sample the driven inputs, advance the model across the edge, then compare.
  task automatic cycle();
    bit          acc, pop, fl;
    logic [31:0] d;
    logic [63:0] rp;
    acc = bus.INST_VALID && rdy_en && (q.size() < 2);
    pop = (q.size() > 0) && bus.DEC_READY;
    fl  = bus.FLUSH;
    rp  = bus.REDIR_PC;
    d   = bus.INST_DATA;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_pc = RST_PC;
    end else if (fl) begin
      q.delete();
      m_pc = rp & ~64'd3;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(ref_decode(d, m_pc));
        m_pc = m_pc + 4;
      end
    end
    rdy_en = rst_n;
    #1;
    check_state();
  endtask

  task automatic directed(input logic [31:0] word, input int cls, input logic [63:0] imm, input int rd);
    bus.INST_DATA  = word;
    bus.INST_VALID = 1'b1;
    cycle();
    bus.INST_VALID = 1'b0;
    chk("dir_class", 64'(bus.DEC_CLASS), 64'(cls));
    chk("dir_imm", bus.DEC_IMM, imm);
    chk("dir_rd", 64'(bus.DEC_RD), 64'(rd));
    cycle();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] word;
    word = $urandom();
    case ($urandom_range(0, 15))
      0:  word[6:0] = 7'h37;
      1:  word[6:0] = 7'h17;
      2:  word[6:0] = 7'h6F;
      3:  word[6:0] = 7'h67;
      4:  word[6:0] = 7'h63;
      5:  word[6:0] = 7'h03;
      6:  word[6:0] = 7'h23;
      7:  word[6:0] = 7'h13;
      8:  word[6:0] = 7'h33;
      9:  word[6:0] = 7'h1B;
      10: word[6:0] = 7'h3B;
      11: word[6:0] = 7'h0F;
      12: word[6:0] = 7'h73;
      default: ;
    endcase
    return word;
  endfunction

  initial begin
    rst_n          = 1'b0;
    bus.INST_VALID = 1'b0;
    bus.INST_DATA  = '0;
    bus.FLUSH      = 1'b0;
    bus.REDIR_PC   = '0;
    bus.DEC_READY  = 1'b0;
    #3;
    chk("rst_dec_valid", 64'(bus.DEC_VALID), 64'd0);
    chk("rst_inst_ready", 64'(bus.INST_READY), 64'd0);
    chk("rst_dec_pc", bus.DEC_PC, 64'd0);
    chk("rst_dec_imm", bus.DEC_IMM, 64'd0);
    cycle();
    rst_n = 1'b1;

    // NOP stream at full throughput
    bus.INST_DATA  = 32'h0000_0013;
    bus.INST_VALID = 1'b1;
    bus.DEC_READY  = 1'b1;
    cycle();
    chk("ready_after_rst", 64'(bus.INST_READY), 64'd1);
    cycle();
    chk("nop_pc0", bus.DEC_PC, 64'h8000_0000);
    cycle();
    chk("nop_pc1", bus.DEC_PC, 64'h8000_0004);
    cycle();
    chk("nop_pc2", bus.DEC_PC, 64'h8000_0008);
    chk("nop_class", 64'(bus.DEC_CLASS), 64'd8);
    chk("nop_imm", bus.DEC_IMM, 64'd0);
    bus.INST_VALID = 1'b0;
    cycle();

    // backpressure: only two beats fit
    bus.DEC_READY  = 1'b0;
    bus.INST_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.INST_DATA = 32'h0000_0093 | (32'(k + 1) << 20);
      cycle();
    end
    chk("bp_ready_low", 64'(bus.INST_READY), 64'd0);
    chk("bp_held_pc", bus.DEC_PC, 64'h8000_000C);
    bus.INST_VALID = 1'b0;
    bus.DEC_READY  = 1'b1;
    repeat (3) cycle();

    directed(32'hFFF0_0093, 8, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    directed(32'h8000_00EF, 3, 64'hFFFF_FFFF_FFF0_0000, 1);
    directed(32'hFE00_0EE3, 5, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    directed(32'h0000_0000, 0, 64'd0, 0);
    chk("ill_rs1", 64'(bus.DEC_RS1), 64'd0);
    directed(32'h0000_7003, 0, 64'd0, 0);

    // flush with both registers full and a beat offered
    bus.DEC_READY  = 1'b0;
    bus.INST_DATA  = 32'h0000_0013;
    bus.INST_VALID = 1'b1;
    repeat (2) cycle();
    bus.FLUSH    = 1'b1;
    bus.REDIR_PC = 64'h8000_1003;
    cycle();
    chk("flush_valid", 64'(bus.DEC_VALID), 64'd0);
    bus.FLUSH     = 1'b0;
    bus.DEC_READY = 1'b1;
    cycle();
    chk("redir_pc", bus.DEC_PC, 64'h8000_1000);
    bus.INST_VALID = 1'b0;
    cycle();

    // random traffic including flushes and PC wrap
    for (int i = 0; i < 3000; i++) begin
      bus.INST_VALID = ($urandom_range(0, 3) != 0);
      bus.DEC_READY  = ($urandom_range(0, 2) != 0);
      bus.INST_DATA  = rand_inst();
      bus.FLUSH      = ($urandom_range(0, 24) == 0);
      bus.REDIR_PC   = ($urandom_range(0, 1) != 0) ? {$urandom(), $urandom()} : 64'hFFFF_FFFF_FFFF_FFF4;
      cycle();
    end
    bus.FLUSH = 1'b0;

    // asynchronous reset while holding valid output
    bus.DEC_READY  = 1'b0;
    bus.INST_VALID = 1'b1;
    bus.INST_DATA  = 32'h0000_0013;
    repeat (2) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.DEC_VALID), 64'd0);
    chk("async_rst_ready", 64'(bus.INST_READY), 64'd0);
    q.delete();
    m_pc   = RST_PC;
    rdy_en = 1'b0;
    repeat (2) cycle();
    rst_n         = 1'b1;
    bus.DEC_READY = 1'b1;
    cycle();
    cycle();
    chk("post_rst_pc", bus.DEC_PC, 64'h8000_0000);
    bus.INST_VALID = 1'b0;
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
